uart_gpio_bridge: RTL and testbench

Parametrised command engine between the UART byte link and the design's GPIO ports, replacing the fixed eight 8-bit in/out pin bank of the MCU top level. It decodes host read/write commands for NUM_PORTS ports of PORT_W bits. It adds input synchronisation, an optional change-notify mode that pushes input changes to the host unsolicited, a command timeout, and receive-overrun reporting. It sits between the UART rx/tx byte cores and the board-level key/LED wiring.

---
 rtl/uart_gpio_bridge.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_uart_gpio_bridge.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_gpio_bridge.sv
// uart_gpio_bridge: byte-command engine between the UART rx/tx byte cores and
// NUM_PORTS GPIO ports of PORT_W bits. It handles host reads and writes, can
// push input changes to the host unsolicited (notify mode), abandons a write
// whose data byte never arrives, and flags dropped receive bytes.
module uart_gpio_bridge #(
  parameter int NUM_PORTS   = 8,
  parameter int PORT_W      = 8,
  parameter int TIMEOUT_CYC = 5_000_000
) (
  input  logic                        sys_clk,
  input  logic                        sys_rst_n,
  input  logic [7:0]                  rx_data,
  input  logic                        rx_valid,
  output logic [7:0]                  tx_data,
  output logic                        tx_valid,
  input  logic                        tx_ready,
  input  logic [NUM_PORTS*PORT_W-1:0] in_bus,
  output logic [NUM_PORTS*PORT_W-1:0] out_bus,
  output logic                        notify_en,
  output logic                        rx_overrun
);

  localparam int                BUS_W    = NUM_PORTS * PORT_W;
  localparam int                TMO_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT_CYC);
  localparam logic [7:0]        ACK      = 8'hAA;
  localparam logic [7:0]        NAK      = 8'hEE;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GET_DATA,
    S_SEND,
    S_SEND_N1,
    S_SEND_N2
  } state_t;

  // Registered state
  state_t             r_state;
  logic [BUS_W-1:0]   r_sync1;
  logic [BUS_W-1:0]   r_sync2;
  logic [BUS_W-1:0]   r_prev;
  logic [BUS_W-1:0]   r_out_bus;
  logic [7:0]         r_tx_data;
  logic               r_tx_valid;
  logic               r_notify_en;
  logic               r_rx_overrun;
  logic               r_pend_valid;
  logic [7:0]         r_pend_data;
  logic [5:0]         r_widx;
  logic [TMO_W-1:0]   r_tmo;
  logic [PORT_W-1:0]  r_nval;

  // Next-state values
  state_t             w_state_next;
  logic [BUS_W-1:0]   w_prev_next;
  logic [BUS_W-1:0]   w_out_bus_next;
  logic [7:0]         w_tx_data_next;
  logic               w_tx_valid_next;
  logic               w_notify_next;
  logic               w_overrun_next;
  logic               w_pend_valid_next;
  logic [7:0]         w_pend_data_next;
  logic [5:0]         w_widx_next;
  logic [TMO_W-1:0]   w_tmo_next;
  logic [PORT_W-1:0]  w_nval_next;

  // Per-port views of the synchronised inputs and their change flags
  logic [PORT_W-1:0]    w_sync_port [NUM_PORTS];
  logic [NUM_PORTS-1:0] w_flag;

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
    assign w_sync_port[gi] = r_sync2[gi*PORT_W +: PORT_W];
    assign w_flag[gi]      = (r_sync2[gi*PORT_W +: PORT_W] != r_prev[gi*PORT_W +: PORT_W]);
  end

  // Byte source: a held pending byte always goes ahead of a fresh rx byte
  logic       w_byte_v;
  logic [7:0] w_byte;
  assign w_byte_v = r_pend_valid | rx_valid;
  assign w_byte   = r_pend_valid ? r_pend_data : rx_data;

  // Lowest-index changed port, for the notify report
  logic              w_hit;
  logic [4:0]        w_hit_idx;
  logic [PORT_W-1:0] w_hit_val;
  always_comb begin
    w_hit     = 1'b0;
    w_hit_idx = '0;
    w_hit_val = '0;
    for (int p = NUM_PORTS - 1; p >= 0; p--) begin
      if (w_flag[p]) begin
        w_hit     = 1'b1;
        w_hit_idx = 5'(p);
        w_hit_val = w_sync_port[p];
      end
    end
  end

  // Read lookup for the port addressed by the current byte
  logic       w_rd_ok;
  logic [7:0] w_rd_val;
  always_comb begin
    w_rd_ok  = 1'b0;
    w_rd_val = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (w_byte[5:0] == 6'(p)) begin
        w_rd_ok  = 1'b1;
        w_rd_val = 8'(w_sync_port[p]);
      end
    end
  end

  // Command decode, write data, notify reports, tx handshake and rx buffering
  logic w_hs, w_expired, w_decode, w_wdata, w_take, w_ovr_set, w_ovr_clr, w_wr_ok;
  always_comb begin
    w_state_next      = r_state;
    w_prev_next       = r_prev;
    w_out_bus_next    = r_out_bus;
    w_tx_data_next    = r_tx_data;
    w_tx_valid_next   = r_tx_valid;
    w_notify_next     = r_notify_en;
    w_pend_valid_next = r_pend_valid;
    w_pend_data_next  = r_pend_data;
    w_widx_next       = r_widx;
    w_tmo_next        = r_tmo;
    w_nval_next       = r_nval;
    w_ovr_set         = 1'b0;
    w_ovr_clr         = 1'b0;
    w_wr_ok           = 1'b0;
    w_hs              = r_tx_valid & tx_ready;
    // On the expiry cycle GET_DATA behaves as IDLE: a byte there is a new command
    w_expired         = (r_state == S_GET_DATA) && (r_tmo == TMO_LAST);
    w_decode          = w_byte_v && ((r_state == S_IDLE) || w_expired);
    w_wdata           = w_byte_v && (r_state == S_GET_DATA) && !w_expired;
    w_take            = w_decode | w_wdata;

    case (r_state)
      S_IDLE: begin
        if (!w_byte_v && r_notify_en && w_hit) begin
          w_tx_data_next  = {3'b110, w_hit_idx};
          w_tx_valid_next = 1'b1;
          w_nval_next     = w_hit_val;
          for (int p = 0; p < NUM_PORTS; p++) begin
            if (w_hit_idx == 5'(p)) w_prev_next[p*PORT_W +: PORT_W] = w_hit_val;
          end
          w_state_next = S_SEND_N1;
        end
      end
      S_GET_DATA: begin
        if (!w_byte_v) begin
          if (w_expired) w_state_next = S_IDLE;
          else           w_tmo_next   = r_tmo + TMO_W'(1);
        end
      end
      S_SEND: begin
        if (w_hs) begin
          w_tx_valid_next = 1'b0;
          w_state_next    = S_IDLE;
        end
      end
      S_SEND_N1: begin
        if (w_hs) begin
          w_tx_data_next = 8'(r_nval);
          w_state_next   = S_SEND_N2;
        end
      end
      S_SEND_N2: begin
        if (w_hs) begin
          w_tx_valid_next = 1'b0;
          w_state_next    = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase

    if (w_decode) begin
      if (w_byte[7]) begin
        w_widx_next  = w_byte[5:0];
        w_tmo_next   = '0;
        w_state_next = S_GET_DATA;
      end else begin
        w_tx_valid_next = 1'b1;
        w_state_next    = S_SEND;
        if (!w_byte[6]) begin
          w_tx_data_next = w_rd_ok ? w_rd_val : NAK;
        end else begin
          case (w_byte)
            8'h7F: begin
              w_notify_next  = 1'b1;
              w_prev_next    = r_sync2;
              w_tx_data_next = ACK;
            end
            8'h7E: begin
              w_notify_next  = 1'b0;
              w_tx_data_next = ACK;
            end
            8'h7D: begin
              w_ovr_clr      = 1'b1;
              w_tx_data_next = ACK;
            end
            default: w_tx_data_next = NAK;
          endcase
        end
      end
    end

    if (w_wdata) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (r_widx == 6'(p)) begin
          w_out_bus_next[p*PORT_W +: PORT_W] = w_byte[PORT_W-1:0];
          w_wr_ok = 1'b1;
        end
      end
      w_tx_data_next  = w_wr_ok ? ACK : NAK;
      w_tx_valid_next = 1'b1;
      w_state_next    = S_SEND;
    end

    // A byte consumed from pending frees the slot for a same-cycle rx byte
    if (w_take) begin
      if (r_pend_valid && rx_valid) w_pend_data_next  = rx_data;
      else                          w_pend_valid_next = 1'b0;
    end else if (rx_valid) begin
      if (!r_pend_valid) begin
        w_pend_valid_next = 1'b1;
        w_pend_data_next  = rx_data;
      end else begin
        w_ovr_set = 1'b1;
      end
    end

    // Setting the overrun flag wins over a same-cycle clear
    w_overrun_next = w_ovr_set ? 1'b1 : (w_ovr_clr ? 1'b0 : r_rx_overrun);
  end

  // Two-flop input synchroniser
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= in_bus;
      r_sync2 <= r_sync1;
    end
  end

  // State and datapath registers
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state      <= S_IDLE;
      r_prev       <= '0;
      r_out_bus    <= '0;
      r_tx_data    <= '0;
      r_tx_valid   <= 1'b0;
      r_notify_en  <= 1'b0;
      r_rx_overrun <= 1'b0;
      r_pend_valid <= 1'b0;
      r_pend_data  <= '0;
      r_widx       <= '0;
      r_tmo        <= '0;
      r_nval       <= '0;
    end else begin
      r_state      <= w_state_next;
      r_prev       <= w_prev_next;
      r_out_bus    <= w_out_bus_next;
      r_tx_data    <= w_tx_data_next;
      r_tx_valid   <= w_tx_valid_next;
      r_notify_en  <= w_notify_next;
      r_rx_overrun <= w_overrun_next;
      r_pend_valid <= w_pend_valid_next;
      r_pend_data  <= w_pend_data_next;
      r_widx       <= w_widx_next;
      r_tmo        <= w_tmo_next;
      r_nval       <= w_nval_next;
    end
  end

  assign tx_data    = r_tx_data;
  assign tx_valid   = r_tx_valid;
  assign out_bus    = r_out_bus;
  assign notify_en  = r_notify_en;
  assign rx_overrun = r_rx_overrun;

endmodule

// File: tb/tb_uart_gpio_bridge.sv
// Directed bench for uart_gpio_bridge (8 ports x 8 bits, 100-cycle timeout).
module tb_uart_gpio_bridge;

  logic        sys_clk;
  logic        sys_rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [63:0] in_bus;
  logic [63:0] out_bus;
  logic        notify_en;
  logic        rx_overrun;

  int checks   = 0;
  int failures = 0;

  uart_gpio_bridge #(
    .NUM_PORTS  (8),
    .PORT_W     (8),
    .TIMEOUT_CYC(100)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .in_bus    (in_bus),
    .out_bus   (out_bus),
    .notify_en (notify_en),
    .rx_overrun(rx_overrun)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s did not match", tag);
    end
    $display("check %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One rx byte per call, held for exactly one clock
  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge sys_clk);
    rx_valid = 1'b0;
  endtask

  // One-cycle tx_ready pulse completes a handshake
  task automatic accept();
    tx_ready = 1'b1;
    @(negedge sys_clk);
    tx_ready = 1'b0;
  endtask

  task automatic set_port(input int i, input logic [7:0] v);
    in_bus[i*8 +: 8] = v;
  endtask

  task automatic wait_tx(input string tag, input int budget);
    int n = 0;
    while (!tx_valid && n < budget) begin
      @(negedge sys_clk);
      n++;
    end
    chk(tag, {63'd0, tx_valid}, 64'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  initial begin
    sys_rst_n = 1'b0;
    rx_data   = 8'h00;
    rx_valid  = 1'b0;
    tx_ready  = 1'b0;
    in_bus    = '0;
    idle(2);
    chk("rst_tx_valid", {63'd0, tx_valid}, 64'd0);
    chk("rst_tx_data", {56'd0, tx_data}, 64'd0);
    chk("rst_out_bus", out_bus, 64'd0);
    chk("rst_notify", {63'd0, notify_en}, 64'd0);
    chk("rst_overrun", {63'd0, rx_overrun}, 64'd0);
    sys_rst_n = 1'b1;
    idle(2);

    // Write port 3
    send_byte(8'h83);
    chk("wr_cmd_no_reply", {63'd0, tx_valid}, 64'd0);
    send_byte(8'h5A);
    chk("wr_out_bus", out_bus, 64'h0000_0000_5A00_0000);
    chk("wr_tx_valid", {63'd0, tx_valid}, 64'd1);
    chk("wr_tx_data", {56'd0, tx_data}, 64'hAA);
    accept();
    chk("wr_tx_drop", {63'd0, tx_valid}, 64'd0);

    // Read port 3 one edge after the input change still sees the old value
    set_port(3, 8'h11);
    send_byte(8'h03);
    chk("rd_sync_lag", {56'd0, tx_data}, 64'h00);
    accept();
    send_byte(8'h03);
    chk("rd_port3", {56'd0, tx_data}, 64'h11);
    accept();

    // Out-of-range indices and unknown command
    send_byte(8'h0A);
    chk("rd_bad_idx", {56'd0, tx_data}, 64'hEE);
    accept();
    send_byte(8'h8A);
    chk("wr_bad_no_reply", {63'd0, tx_valid}, 64'd0);
    send_byte(8'hFF);
    chk("wr_bad_idx", {56'd0, tx_data}, 64'hEE);
    chk("wr_bad_out_bus", out_bus, 64'h0000_0000_5A00_0000);
    accept();
    send_byte(8'h55);
    chk("bad_cmd", {56'd0, tx_data}, 64'hEE);
    accept();

    // Notify enable: no spurious report for the already-high port 3
    send_byte(8'h7F);
    chk("ntf_en_ack", {56'd0, tx_data}, 64'hAA);
    chk("ntf_en_flag", {63'd0, notify_en}, 64'd1);
    accept();
    idle(4);
    chk("ntf_no_spurious", {63'd0, tx_valid}, 64'd0);

    // Two ports change together: lowest index reported first
    set_port(1, 8'h04);
    set_port(5, 8'h01);
    wait_tx("ntf_wait1", 10);
    chk("ntf1_hdr", {56'd0, tx_data}, 64'hC1);
    accept();
    chk("ntf1_val_valid", {63'd0, tx_valid}, 64'd1);
    chk("ntf1_val", {56'd0, tx_data}, 64'h04);
    accept();
    wait_tx("ntf_wait5", 10);
    chk("ntf5_hdr", {56'd0, tx_data}, 64'hC5);
    accept();
    chk("ntf5_val", {56'd0, tx_data}, 64'h01);
    accept();
    idle(4);
    chk("ntf_done", {63'd0, tx_valid}, 64'd0);

    // Notify disable: changes go unreported
    send_byte(8'h7E);
    chk("ntf_dis_ack", {56'd0, tx_data}, 64'hAA);
    chk("ntf_dis_flag", {63'd0, notify_en}, 64'd0);
    accept();
    set_port(1, 8'h00);
    set_port(2, 8'h3C);
    idle(6);
    chk("ntf_dis_quiet", {63'd0, tx_valid}, 64'd0);

    // Data byte after 99 idle cycles is still accepted
    send_byte(8'h84);
    idle(99);
    send_byte(8'h33);
    chk("tmo_edge_ack", {56'd0, tx_data}, 64'hAA);
    chk("tmo_edge_out", out_bus, 64'h0000_0033_5A00_0000);
    accept();

    // After 100 idle cycles the write is abandoned; next byte is a read
    send_byte(8'h82);
    idle(100);
    send_byte(8'h02);
    chk("tmo_read_reply", {56'd0, tx_data}, 64'h3C);
    chk("tmo_out_unchanged", out_bus, 64'h0000_0033_5A00_0000);
    accept();

    // Overrun: first replied, second pending, third dropped
    send_byte(8'h03);
    send_byte(8'h02);
    send_byte(8'h01);
    chk("ovr_first", {56'd0, tx_data}, 64'h11);
    chk("ovr_flag", {63'd0, rx_overrun}, 64'd1);
    accept();
    chk("ovr_gap", {63'd0, tx_valid}, 64'd0);
    @(negedge sys_clk);
    chk("ovr_pend_valid", {63'd0, tx_valid}, 64'd1);
    chk("ovr_pend_data", {56'd0, tx_data}, 64'h3C);
    accept();
    idle(3);
    chk("ovr_third_dropped", {63'd0, tx_valid}, 64'd0);
    send_byte(8'h7D);
    chk("ovr_clr_ack", {56'd0, tx_data}, 64'hAA);
    chk("ovr_clr_flag", {63'd0, rx_overrun}, 64'd0);
    accept();

    // Asynchronous reset while a notify header is stalled
    send_byte(8'h7F);
    accept();
    set_port(6, 8'h77);
    wait_tx("rst_ntf_wait", 10);
    chk("rst_ntf_hdr", {56'd0, tx_data}, 64'hC6);
    #2;
    sys_rst_n = 1'b0;
    #1;
    chk("arst_tx_valid", {63'd0, tx_valid}, 64'd0);
    chk("arst_tx_data", {56'd0, tx_data}, 64'd0);
    chk("arst_out_bus", out_bus, 64'd0);
    chk("arst_notify", {63'd0, notify_en}, 64'd0);
    chk("arst_overrun", {63'd0, rx_overrun}, 64'd0);
    idle(2);
    sys_rst_n = 1'b1;
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
